// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one memory read per PC, holds the returned
// word for decode, and latches a sticky error if memory never answers.
module fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  next_pc,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [15:0]        retired_cnt,
  output logic               fetch_err
);

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERROR} state_t;

  state_t              state, state_next;
  logic [7:0]          wait_cnt;
  logic                accept, handshake;
  logic [ADDR_W-1:0]   pc_next;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_out;
    accept     = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE:  if (start) state_next = FETCH;
      FETCH: begin
        // an ack in the final watchdog cycle still completes the fetch
        if (imem_ack) begin
          accept     = 1'b1;
          state_next = HOLD;
        end else if (wait_cnt == TIMEOUT_W) begin
          state_next = ERROR;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          handshake  = 1'b1;
          pc_next    = next_pc;
          state_next = start ? FETCH : IDLE;
        end
      end
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out      <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      retired_cnt <= '0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      pc_out      <= pc_next;
      imem_addr   <= pc_next;
      imem_req    <= (state_next == FETCH);
      instr_valid <= (state_next == HOLD);
      fetch_err   <= (state_next == ERROR);
      if (accept) begin
        instr_out <= imem_data;
        instr_pc  <= pc_out;
      end
      if (handshake && retired_cnt != 16'hFFFF)
        retired_cnt <= retired_cnt + 16'd1;
      if (state != FETCH)
        wait_cnt <= '0;
      else if (!imem_ack)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 16, meaning program-counter and instruction-memory address width.
REQ-002 The module SHALL have parameter INSTR_W, default 16, meaning instruction word width.
REQ-003 The module SHALL have parameter TIMEOUT, default 15, meaning maximum FETCH cycles without imem_ack before error; legal range 1..255.
REQ-004 Ports (clock and reset first):
- clk  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  run enable; equivalent of the next-address stage's ready.
- next_pc  input  ADDR_W  next address computed combinationally from pc_out.
- pc_out  output  ADDR_W  current PC, fed back as the next-address stage's old.
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  ADDR_W  read address, valid while imem_req=1.
- imem_ack  input  1  memory response strobe, one cycle.
- imem_data  input  INSTR_W  instruction word, valid when imem_ack=1.
- instr_valid  output  1  instr_out holds an instruction for decode.
- instr_ready  input  1  decode accepts instr_out this cycle.
- instr_out  output  INSTR_W  held instruction.
- instr_pc  output  ADDR_W  address instr_out was fetched from.
- retired_cnt  output  16  count of accepted instructions.
- fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-005 The FSM SHALL have four states: IDLE, FETCH, HOLD, ERROR.
REQ-006 All outputs SHALL be registered; no combinational input-to-output path.
REQ-007 IDLE: imem_req=0, instr_valid=0; start=1 -> FETCH next cycle, else remain.
REQ-008 FETCH: imem_req=1 and imem_addr=pc_out, both stable until the ack cycle.
REQ-009 FETCH with imem_ack=1: capture imem_data into instr_out and pc_out into instr_pc; go HOLD; instr_valid=1 and imem_req=0 from the next cycle.
REQ-010 Minimum latency SHALL be: start sampled high in IDLE -> imem_req high the next cycle; ack in cycle N -> instr_valid high in cycle N+1.
REQ-011 HOLD: instr_valid=1; instr_out and instr_pc stable until handshake.
REQ-012 HOLD with instr_ready=1 (handshake): pc_out<=next_pc, retired_cnt increments, instr_valid=0 next cycle; go FETCH if start=1, else IDLE.
REQ-013 HOLD with instr_ready=0: state, pc_out and retired_cnt unchanged.
REQ-014 start=0 while in FETCH SHALL NOT abort the outstanding request; start is only sampled in IDLE and at the HOLD handshake.
REQ-015 imem_ack while imem_req=0 (IDLE, HOLD, ERROR) SHALL be ignored.
REQ-016 Watchdog: an 8-bit wait counter clears on FETCH entry and increments each FETCH cycle without imem_ack.
REQ-017 When the wait counter reaches TIMEOUT with imem_ack=0, the next state SHALL be ERROR.
REQ-018 If imem_ack=1 in the same cycle the wait counter reaches TIMEOUT, the ack SHALL win and the next state SHALL be HOLD.
REQ-019 ERROR: fetch_err=1, imem_req=0, instr_valid=0; pc_out held; exit only by reset.
REQ-020 retired_cnt SHALL saturate at 16'hFFFF.
REQ-021 pc_out SHALL load next_pc verbatim, with no width extension; wrap-around is owned by the next-address stage.

Reset
REQ-022 reset=1 at a rising edge SHALL force state IDLE, pc_out=0, imem_req=0, imem_addr=0, instr_valid=0, instr_out=0, instr_pc=0, retired_cnt=0, fetch_err=0, wait counter=0.
REQ-023 Reset SHALL take priority over every other input, including mid-FETCH, mid-HOLD and in ERROR; any outstanding request is abandoned, and a late imem_ack after reset is ignored per REQ-015.

Verification
REQ-024 Bench SHALL cover: reset, start=1, next_pc=pc_out+1, ack after 1 cycle with 16'hA001, instr_ready=1 -> imem_addr 0,1,2 in order, instr_out=16'hA001 with instr_pc=0, retired_cnt=3 after three handshakes.
REQ-025 Bench SHALL cover: in HOLD at pc=5, instr_ready=0 for 4 cycles, then 1, with next_pc=16'h0003 (taken jump) -> instr_out stable for 4 cycles, next imem_addr=3.
REQ-026 Bench SHALL cover: TIMEOUT=15, no ack -> imem_req high exactly 16 cycles, then fetch_err=1 and imem_req=0; reset clears fetch_err and pc_out=0.
REQ-027 Bench SHALL cover: ack arriving on the 16th FETCH cycle -> HOLD entered, fetch_err stays 0.
REQ-028 Bench SHALL cover: reset asserted during FETCH with ack in the following cycle -> imem_req=0 the cycle after reset, ack ignored, instr_valid stays 0.
REQ-029 Bench SHALL cover: start=0 at the handshake -> IDLE, pc_out=next_pc, imem_req stays 0 until start=1.
